// File: rtl/l1_cache_pkg.sv
// Shared L1 cache geometry and the refill FSM state encoding, used by the
// refill buffer today and by the cache controller later.
package l1_cache_pkg;
  localparam int LINE_BITS     = 1024;
  localparam int BEAT_BITS     = 64;
  localparam int SET_BITS      = 8;
  localparam int BEATS         = LINE_BITS / BEAT_BITS;
  localparam int WMASK_BITS    = LINE_BITS / 8;
  localparam int BEAT_CNT_BITS = $clog2(BEATS);

  typedef logic [SET_BITS-1:0] set_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } refill_state_e;
endpackage

// File: rtl/l1_refill_buffer_if.sv
// Refill request / beat stream / SRAM write port / status bundle of the
// refill buffer. slave = the refill buffer, master = the surrounding logic.
interface l1_refill_buffer_if;
  import l1_cache_pkg::*;

  logic                  req_valid;
  set_idx_t              req_set;
  logic                  req_ready;
  logic                  beat_valid;
  logic [BEAT_BITS-1:0]  beat_data;
  logic                  beat_last;
  logic                  beat_ready;
  logic                  sram_csb;
  set_idx_t              sram_addr;
  logic [WMASK_BITS-1:0] sram_wmask;
  logic [LINE_BITS-1:0]  sram_din;
  logic                  fill_active;
  set_idx_t              fill_set;
  logic                  done_valid;
  set_idx_t              done_set;
  logic                  err;

  modport slave (
    input  req_valid, req_set, beat_valid, beat_data, beat_last,
    output req_ready, beat_ready, sram_csb, sram_addr, sram_wmask, sram_din,
           fill_active, fill_set, done_valid, done_set, err
  );

  modport master (
    output req_valid, req_set, beat_valid, beat_data, beat_last,
    input  req_ready, beat_ready, sram_csb, sram_addr, sram_wmask, sram_din,
           fill_active, fill_set, done_valid, done_set, err
  );
endinterface

// File: rtl/l1_line_assembler.sv
// Beat counter plus beat-indexed line register; flags a correctly terminated
// line or a malformed beat stream on the accepting handshake.
module l1_line_assembler
  import l1_cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic                 beat_fire_i,
  input  logic [BEAT_BITS-1:0] beat_data_i,
  input  logic                 beat_last_i,
  output logic [LINE_BITS-1:0] line_o,
  output logic                 last_ok_o,
  output logic                 stream_err_o
);
  logic [BEAT_CNT_BITS-1:0] cnt_q, cnt_d;
  logic                     at_final;

  assign at_final = (cnt_q == BEAT_CNT_BITS'(BEATS - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (beat_fire_i)
      cnt_d = cnt_q + BEAT_CNT_BITS'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  // Line storage is never reset or cleared: every beat slot is rewritten
  // before a line can reach the SRAM.
  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
      logic [BEAT_BITS-1:0] beat_q;

      always_ff @(posedge clk) begin
        if (beat_fire_i && (cnt_q == BEAT_CNT_BITS'(gi)))
          beat_q <= beat_data_i;
      end

      assign line_o[gi*BEAT_BITS +: BEAT_BITS] = beat_q;
    end
  endgenerate

  assign last_ok_o    = beat_fire_i && at_final && beat_last_i;
  assign stream_err_o = beat_fire_i && (beat_last_i != at_final);
endmodule

// File: rtl/l1_refill_buffer.sv
// Refill FSM: gathers BEATS beats into a line, commits it with one full-mask
// SRAM write, and reports the in-flight set to the read pipeline.
module l1_refill_buffer
  import l1_cache_pkg::*;
(
  input logic               clk,
  input logic               rst,
  l1_refill_buffer_if.slave bus
);
  refill_state_e         state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  beat_ready_q, beat_ready_d;
  logic                  sram_csb_q, sram_csb_d;
  set_idx_t              sram_addr_q, sram_addr_d;
  logic [WMASK_BITS-1:0] sram_wmask_q, sram_wmask_d;
  logic                  fill_active_q, fill_active_d;
  set_idx_t              fill_set_q, fill_set_d;
  logic                  done_valid_q, done_valid_d;
  set_idx_t              done_set_q, done_set_d;
  logic                  err_q, err_d;

  logic                  accept, beat_fire, last_ok, stream_err;
  logic [LINE_BITS-1:0]  line;

  // The ready registers are high exactly in IDLE / FILL, so they qualify
  // the handshakes without a separate state decode.
  assign accept    = bus.req_valid && req_ready_q;
  assign beat_fire = bus.beat_valid && beat_ready_q;

  l1_line_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (accept),
    .beat_fire_i  (beat_fire),
    .beat_data_i  (bus.beat_data),
    .beat_last_i  (bus.beat_last),
    .line_o       (line),
    .last_ok_o    (last_ok),
    .stream_err_o (stream_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      req_ready_q   <= 1'b1;
      beat_ready_q  <= 1'b0;
      sram_csb_q    <= 1'b1;
      sram_addr_q   <= '0;
      sram_wmask_q  <= '0;
      fill_active_q <= 1'b0;
      fill_set_q    <= '0;
      done_valid_q  <= 1'b0;
      done_set_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      beat_ready_q  <= beat_ready_d;
      sram_csb_q    <= sram_csb_d;
      sram_addr_q   <= sram_addr_d;
      sram_wmask_q  <= sram_wmask_d;
      fill_active_q <= fill_active_d;
      fill_set_q    <= fill_set_d;
      done_valid_q  <= done_valid_d;
      done_set_q    <= done_set_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_FILL;
      ST_FILL: begin
        if (stream_err)
          state_d = ST_IDLE;
        else if (last_ok)
          state_d = ST_WRITE;
      end
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so each one
  // lines up with the cycle its state is occupied.
  always_comb begin
    req_ready_d   = (state_d == ST_IDLE);
    beat_ready_d  = (state_d == ST_FILL);
    sram_csb_d    = (state_d != ST_WRITE);
    sram_addr_d   = (state_d == ST_WRITE) ? fill_set_q : sram_addr_q;
    sram_wmask_d  = (state_d == ST_WRITE) ? '1 : '0;
    fill_active_d = (state_d != ST_IDLE);
    fill_set_d    = accept ? bus.req_set : fill_set_q;
    done_valid_d  = (state_d == ST_DONE);
    done_set_d    = (state_d == ST_DONE) ? fill_set_q : done_set_q;
    err_d         = (state_q == ST_FILL) && stream_err;
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.beat_ready  = beat_ready_q;
  assign bus.sram_csb    = sram_csb_q;
  assign bus.sram_addr   = sram_addr_q;
  assign bus.sram_wmask  = sram_wmask_q;
  assign bus.sram_din    = line;
  assign bus.fill_active = fill_active_q;
  assign bus.fill_set    = fill_set_q;
  assign bus.done_valid  = done_valid_q;
  assign bus.done_set    = done_set_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_l1_refill_buffer.sv
// Bench for l1_refill_buffer: directed and random refills against a simple
// outcome model and a behavioural 1R1W SRAM fed by the write port.
module tb_l1_refill_buffer;
  import l1_cache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l1_refill_buffer_if bus ();

  l1_refill_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: samples the write at posedge, updates the array at the
  // following negedge.
  logic [LINE_BITS-1:0]  mem [256];
  logic                  wr_pend = 1'b0;
  logic [SET_BITS-1:0]   wr_addr;
  logic [WMASK_BITS-1:0] wr_mask;
  logic [LINE_BITS-1:0]  wr_data;
  int                    wr_cnt = 0;

  always @(posedge clk) begin
    wr_pend <= !bus.sram_csb;
    if (!bus.sram_csb) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= bus.sram_addr;
      wr_mask <= bus.sram_wmask;
      wr_data <= bus.sram_din;
    end
  end

  always @(negedge clk) begin
    if (wr_pend)
      for (int b = 0; b < WMASK_BITS; b++)
        if (wr_mask[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic reset_values(input string pfx);
    check({pfx, "_req_ready"},   64'(bus.req_ready),   64'd1);
    check({pfx, "_sram_csb"},    64'(bus.sram_csb),    64'd1);
    check({pfx, "_beat_ready"},  64'(bus.beat_ready),  64'd0);
    check({pfx, "_fill_active"}, 64'(bus.fill_active), 64'd0);
    check({pfx, "_done_valid"},  64'(bus.done_valid),  64'd0);
    check({pfx, "_err"},         64'(bus.err),         64'd0);
    check({pfx, "_sram_addr"},   64'(bus.sram_addr),   64'd0);
    check({pfx, "_wmask_zero"},  64'(bus.sram_wmask == '0), 64'd1);
    check({pfx, "_fill_set"},    64'(bus.fill_set),    64'd0);
    check({pfx, "_done_set"},    64'(bus.done_set),    64'd0);
  endtask

  // One refill transaction. last_at = beat index carrying beat_last
  // (-1: never). Commit is expected only when beat_last is first seen on the
  // final beat. cut = assert reset during the WRITE cycle.
  task automatic refill(input logic [SET_BITS-1:0] set, input int last_at,
                        input int gap_min, input int gap_max,
                        input bit pattern, input bit cut);
    logic [BEAT_BITS-1:0] beats [BEATS];
    logic [LINE_BITS-1:0] exp_line, snap;
    int nb, wr0, bad, waited;
    bit ok;
    string res;

    ok     = (last_at == BEATS - 1);
    nb     = (last_at >= 0 && last_at < BEATS) ? last_at + 1 : BEATS;
    waited = 0;
    while (!bus.req_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("req_ready_before_request", 64'(bus.req_ready), 64'd1);
    snap = mem[set];
    wr0  = wr_cnt;

    bus.req_valid = 1'b1;
    bus.req_set   = set;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_set   = SET_BITS'($urandom);
    check("fill_set_latched", 64'(bus.fill_set), 64'(set));

    bad = 0;
    for (int k = 0; k < nb; k++) begin
      int gap;
      gap = int'($urandom_range(gap_max, gap_min));
      for (int g = 0; g < gap; g++) begin
        bus.beat_valid = 1'b0;
        bus.beat_data  = {$urandom, $urandom};
        bus.beat_last  = 1'($urandom);
        if (bus.fill_active !== 1'b1 || bus.beat_ready !== 1'b1) bad++;
        @(negedge clk);
      end
      beats[k] = pattern ? {8{8'(k)}} : {$urandom, $urandom};
      if (bus.fill_active !== 1'b1 || bus.beat_ready !== 1'b1) bad++;
      bus.beat_valid = 1'b1;
      bus.beat_data  = beats[k];
      bus.beat_last  = (k == last_at);
      @(negedge clk);
    end
    bus.beat_valid = 1'b0;
    bus.beat_last  = 1'b0;
    check("active_and_ready_during_fill", 64'(bad), 64'd0);

    if (ok) begin
      for (int k = 0; k < BEATS; k++) exp_line[k*BEAT_BITS +: BEAT_BITS] = beats[k];
      check("write_csb_low",    64'(bus.sram_csb),    64'd0);
      check("write_addr",       64'(bus.sram_addr),   64'(set));
      check("write_mask_ones",  64'(&bus.sram_wmask), 64'd1);
      check("write_fill_active", 64'(bus.fill_active), 64'd1);
      check("write_beat_ready", 64'(bus.beat_ready),  64'd0);
      for (int k = 0; k < BEATS; k++)
        check($sformatf("write_din_beat%0d", k), bus.sram_din[k*BEAT_BITS +: BEAT_BITS], beats[k]);
    end else begin
      check("abort_err_pulse",   64'(bus.err),         64'd1);
      check("abort_fill_active", 64'(bus.fill_active), 64'd0);
      check("abort_req_ready",   64'(bus.req_ready),   64'd1);
      check("abort_csb_high",    64'(bus.sram_csb),    64'd1);
    end

    if (ok && cut) begin
      #1 rst = 1'b1;
      #1;
      reset_values("cut");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("cut_no_done",     64'(bus.done_valid), 64'd0);
      check("cut_no_err",      64'(bus.err),        64'd0);
      check("cut_write_count", 64'(wr_cnt - wr0),   64'd0);
      check("cut_sram_unchanged", 64'(mem[set] === snap), 64'd1);
      res = "reset-cut";
    end else if (ok) begin
      @(negedge clk);
      check("done_valid",      64'(bus.done_valid),  64'd1);
      check("done_set",        64'(bus.done_set),    64'(set));
      check("done_csb_high",   64'(bus.sram_csb),    64'd1);
      check("done_fill_active", 64'(bus.fill_active), 64'd1);
      @(negedge clk);
      check("after_done_pulse",  64'(bus.done_valid),  64'd0);
      check("after_req_ready",   64'(bus.req_ready),   64'd1);
      check("after_fill_active", 64'(bus.fill_active), 64'd0);
      check("commit_write_count", 64'(wr_cnt - wr0),  64'd1);
      check("sram_readback_line", 64'(mem[set] === exp_line), 64'd1);
      res = "commit";
    end else begin
      @(negedge clk);
      check("abort_err_one_cycle", 64'(bus.err),        64'd0);
      check("abort_no_done",       64'(bus.done_valid), 64'd0);
      check("abort_write_count",   64'(wr_cnt - wr0),   64'd0);
      check("abort_sram_unchanged", 64'(mem[set] === snap), 64'd1);
      res = "abort";
    end
    $display("refill set=%02h beats=%0d last_at=%0d gaps=%0d..%0d -> %s",
             set, nb, last_at, gap_min, gap_max, res);
  endtask

  initial begin
    int bad, r, la;

    bus.req_valid  = 1'b0;
    bus.req_set    = '0;
    bus.beat_valid = 1'b0;
    bus.beat_data  = '0;
    bus.beat_last  = 1'b0;

    repeat (2) @(negedge clk);
    reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    refill(8'h2A, BEATS - 1, 0, 0, 1'b1, 1'b0);
    refill(8'h51, BEATS - 1, 3, 3, 1'b0, 1'b0);
    refill(8'h17, 5, 0, 1, 1'b0, 1'b0);
    refill(8'hFF, BEATS - 1, 0, 0, 1'b1, 1'b0);
    refill(8'h40, -1, 0, 0, 1'b0, 1'b0);

    bad = 0;
    for (int i = 0; i < 4; i++) begin
      bus.beat_valid = 1'b1;
      bus.beat_data  = {$urandom, $urandom};
      bus.beat_last  = 1'(i & 1);
      @(negedge clk);
      if (bus.beat_ready !== 1'b0 || bus.req_ready !== 1'b1 ||
          bus.fill_active !== 1'b0 || bus.err !== 1'b0) bad++;
    end
    bus.beat_valid = 1'b0;
    bus.beat_last  = 1'b0;
    check("idle_beats_ignored", 64'(bad), 64'd0);
    $display("idle beats x4 while IDLE -> ignored");
    refill(8'h05, BEATS - 1, 0, 0, 1'b1, 1'b0);

    refill(8'h33, BEATS - 1, 0, 0, 1'b0, 1'b1);
    refill(8'h33, BEATS - 1, 0, 1, 1'b0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      r  = int'($urandom_range(9, 0));
      la = (r == 0) ? int'($urandom_range(BEATS - 2, 0)) : (r == 1) ? -1 : BEATS - 1;
      refill(SET_BITS'($urandom), la, 0, 2, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
